regfile_wr_arbiter: RTL and testbench

//  Shares the single write port of the 32 x 64-bit register file among NUM_REQ requesters
//  (e.g. ALU writeback, load writeback, debug port).
//  - Round-robin grant, valid/ready handshake per requester.
//  - Drives the per-register one-hot write enables and the shared 64-bit write data.
//  - X31 is the hardwired zero register: never enabled.

---
 rtl/regfile_pkg.sv | 25 ++
 rtl/regfile_wr_arbiter_rr_arbiter.sv | 38 +++
 rtl/regfile_wr_arbiter.sv | 115 +++++++++++
 tb/tb_regfile_wr_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write path.
// Latency: n/a (package only).
// Backpressure: n/a.
//
// Contents: register address/data widths, the hardwired-zero register index,
// and a helper that decides whether an address names a writable register.
package regfile_pkg;

    localparam int REG_AW = 5;
    localparam int NREGS  = 32;
    localparam int DW     = 64;

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [DW-1:0]     reg_data_t;

    // X31 always reads as zero, so writes to it are granted but never land.
    localparam reg_addr_t ZERO_REG = 5'd31;

    // True when a write to 'addr' should actually reach the file: not the
    // zero register and inside the populated range.
    function automatic logic addr_writable(input reg_addr_t addr, input int unsigned nregs);
        return (addr != ZERO_REG) && (32'(addr) < nregs);
    endfunction

endpackage

// File: rtl/regfile_wr_arbiter_rr_arbiter.sv
// Round-robin priority picker: one-hot grant starting the search at ptr.
// Latency: purely combinational, zero cycles.
// Backpressure: none; a request is either picked this cycle or left pending.
//
// Ports:
//   req        in   N    request vector
//   ptr        in   IW   index with highest priority this cycle
//   grant      out  N    one-hot grant (all zero when no request)
//   grant_idx  out  IW   index of the granted request
//   grant_vld  out  1    any request granted
module rr_arbiter
    import regfile_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_vld
);

    // Walk ptr, ptr+1, ... mod N and take the first asserted request.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!grant_vld && req[(int'(ptr) + k) % N]) begin
                grant[(int'(ptr) + k) % N] = 1'b1;
                grant_idx                  = IW'((int'(ptr) + k) % N);
                grant_vld                  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the register file's single write port among NUM_REQ requesters (round robin).
// Latency: grant is combinational in cycle N; wr_en/wr_data are registered and appear in N+1.
// Backpressure: req_ready is a one-hot grant; losers keep valid/addr/data stable until ready.
//
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   req_valid    per-requester write pending
//   req_addr     packed destination registers, requester i at [5i+:5]
//   req_data     packed write data, requester i at [DW*i+:DW]
//   req_ready    one-hot grant; transfer completes on valid & ready
//   wr_en        one-hot register enables into the file (X31 never enabled)
//   wr_data      shared write data to every register D input
//   busy         any req_valid high this cycle
//   wr_count     writes that actually reached the file since reset (wrapping)
module regfile_wr_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int NREGS   = regfile_pkg::NREGS,
    parameter int DW      = regfile_pkg::DW
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*REG_AW-1:0] req_addr,
    input  logic [NUM_REQ*DW-1:0]     req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NREGS-1:0]          wr_en,
    output logic [DW-1:0]             wr_data,
    output logic                      busy,
    output logic [15:0]               wr_count
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IW-1:0]      rr_ptr_q,   rr_ptr_d;
    logic [NREGS-1:0]   wr_en_q,    wr_en_d;
    logic [DW-1:0]      wr_data_q,  wr_data_d;
    logic [15:0]        wr_count_q, wr_count_d;

    logic [NUM_REQ-1:0] arb_grant;
    logic [IW-1:0]      arb_idx;
    logic               arb_vld;
    logic               grant_ok;
    reg_addr_t          sel_addr;
    logic [DW-1:0]      sel_data;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (rr_ptr_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .grant_vld (arb_vld)
    );

    // Nothing is granted while reset is held, so requesters keep their
    // writes and re-present them once reset drops.
    assign grant_ok  = arb_vld & ~reset;
    assign req_ready = reset ? '0 : arb_grant;
    assign busy      = |req_valid;

    // Mux the granted requester's address and data.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (int'(arb_idx) == i) begin
                sel_addr = req_addr[i*REG_AW +: REG_AW];
                sel_data = req_data[i*DW +: DW];
            end
        end
    end

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        wr_en_d    = '0;
        wr_data_d  = wr_data_q;
        wr_count_d = wr_count_q;
        if (grant_ok) begin
            rr_ptr_d = (int'(arb_idx) == NUM_REQ - 1) ? '0 : arb_idx + IW'(1);
            // X31 and out-of-range writes retire without touching the file,
            // wr_data or the commit counter.
            if (addr_writable(sel_addr, NREGS)) begin
                wr_en_d    = NREGS'(1) << sel_addr;
                wr_data_d  = sel_data;
                wr_count_d = wr_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q   <= '0;
            wr_en_q    <= '0;
            wr_data_q  <= '0;
            wr_count_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            wr_en_q    <= wr_en_d;
            wr_data_q  <= wr_data_d;
            wr_count_q <= wr_count_d;
        end
    end

    // A commit already in the output register when reset arrives must not
    // reach the file at the edge ending the reset cycle, so reset also masks
    // the enables directly.
    assign wr_en    = reset ? '0 : wr_en_q;
    assign wr_data  = wr_data_q;
    assign wr_count = wr_count_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Scoreboard bench for regfile_wr_arbiter.
// Latency: expects grants in the issue cycle and commits one cycle later.
// Backpressure: requesters hold valid until granted, then drop or re-present.
module tb_regfile_wr_arbiter;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  req_valid;
    logic [N*5-1:0]  req_addr;
    logic [N*64-1:0] req_data;
    logic [N-1:0]  req_ready;
    logic [31:0]   wr_en;
    logic [63:0]   wr_data;
    logic          busy;
    logic [15:0]   wr_count;

    typedef struct packed {
        logic [31:0] en;
        logic [63:0] data;
    } commit_t;

    int      grant_q[$];
    commit_t commit_q[$];
    int      checks   = 0;
    int      failures = 0;

    regfile_wr_arbiter #(.NUM_REQ(N), .NREGS(32), .DW(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .busy      (busy),
        .wr_count  (wr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic put(input int i, input logic v, input logic [4:0] a, input logic [63:0] d);
        req_valid[i]      = v;
        req_addr[i*5 +: 5]  = a;
        req_data[i*64 +: 64] = d;
    endtask

    // Record the grant expected this cycle and, if the write should land,
    // the commit expected on the next cycle.
    task automatic expect_grant(input int g, input logic [4:0] a, input logic [63:0] d, input bit lands);
        commit_t c;
        grant_q.push_back(g);
        if (lands) begin
            c.en   = 32'b1 << a;
            c.data = d;
            commit_q.push_back(c);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: samples on the falling edge, pops the scoreboard whenever the
    // DUT shows a grant or a write enable.
    initial begin
        int      g;
        commit_t c;
        forever begin
            @(negedge clk);
            if (req_ready != '0) begin
                chk("ready_onehot", 64'($onehot(req_ready)), 64'd1);
                if (grant_q.size() == 0) begin
                    chk("unexpected_grant", 64'(req_ready), 64'd0);
                end else begin
                    g = grant_q.pop_front();
                    chk("grant", 64'(req_ready), 64'(4'b1 << g));
                end
            end
            if (wr_en != '0) begin
                if (commit_q.size() == 0) begin
                    chk("unexpected_wr_en", 64'(wr_en), 64'd0);
                end else begin
                    c = commit_q.pop_front();
                    chk("wr_en", 64'(wr_en), 64'(c.en));
                    chk("wr_data", wr_data, c.data);
                end
            end
        end
    end

    localparam logic [63:0] DATA_A = 64'hAAAA_0000_0000_000A;
    localparam logic [63:0] DATA_B = 64'hBBBB_0000_0000_000B;
    localparam logic [63:0] DATA_C = 64'hCCCC_0000_0000_000C;

    initial begin
        int exp_order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        int n_i;
        int g;

        // 1. Reset held two cycles with every requester valid.
        reset     = 1'b1;
        req_valid = '1;
        req_addr  = '0;
        req_data  = '0;
        for (int cyc = 0; cyc < 2; cyc++) begin
            @(negedge clk);
            chk("rst_ready", 64'(req_ready), 64'd0);
            chk("rst_wr_en", 64'(wr_en), 64'd0);
            chk("rst_wr_count", 64'(wr_count), 64'd0);
            chk("rst_wr_data", wr_data, 64'd0);
        end
        tick();
        reset     = 1'b0;
        req_valid = '0;

        // 2. Single write from requester 1 (rr_ptr 0 -> 2).
        put(1, 1'b1, 5'd5, 64'hDEAD_BEEF);
        expect_grant(1, 5'd5, 64'hDEAD_BEEF, 1'b1);
        tick();
        put(1, 1'b0, 5'd0, 64'd0);
        tick();
        @(negedge clk);
        chk("idle_wr_en", 64'(wr_en), 64'd0);
        chk("hold_wr_data", wr_data, 64'hDEAD_BEEF);
        chk("count_after_single", 64'(wr_count), 64'd1);
        chk("idle_busy", 64'(busy), 64'd0);
        tick();

        // Requester 3 alone brings rr_ptr back to 0.
        put(3, 1'b1, 5'd10, 64'h0A);
        expect_grant(3, 5'd10, 64'h0A, 1'b1);
        tick();
        put(3, 1'b0, 5'd0, 64'd0);

        // 3. All four valid for eight cycles; each requester presents its next
        //    write (data bumps by 0x10 per completed write) after being granted.
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < N; i++) begin
                n_i = c / 4 + ((i < c % 4) ? 1 : 0);
                put(i, 1'b1, 5'(i + 1), 64'h3000 + 64'(n_i * 16 + i));
            end
            g = exp_order[c];
            expect_grant(g, 5'(g + 1), 64'h3000 + 64'((c / 4) * 16 + g), 1'b1);
            tick();
        end
        req_valid = '0;
        tick();
        @(negedge clk);
        chk("count_after_rr", 64'(wr_count), 64'd10);
        tick();

        // 4. Requester 2 writes X31: granted, nothing lands (rr_ptr -> 3).
        put(2, 1'b1, 5'd31, 64'h1);
        expect_grant(2, 5'd31, 64'h1, 1'b0);
        tick();
        put(2, 1'b0, 5'd0, 64'd0);
        @(negedge clk);
        chk("x31_wr_en", 64'(wr_en), 64'd0);
        chk("x31_count", 64'(wr_count), 64'd10);
        tick();
        @(negedge clk);
        chk("x31_count_later", 64'(wr_count), 64'd10);
        tick();

        // 5. Requesters 0 and 3 both write X7 with rr_ptr at 3: 3 goes first.
        put(0, 1'b1, 5'd7, DATA_A);
        put(3, 1'b1, 5'd7, DATA_B);
        expect_grant(3, 5'd7, DATA_B, 1'b1);
        @(negedge clk);
        chk("busy_two_valid", 64'(busy), 64'd1);
        tick();
        put(3, 1'b0, 5'd0, 64'd0);
        expect_grant(0, 5'd7, DATA_A, 1'b1);
        tick();
        req_valid = '0;
        tick();
        @(negedge clk);
        chk("same_addr_last", wr_data, DATA_A);
        chk("same_addr_idle_en", 64'(wr_en), 64'd0);
        chk("count_after_same", 64'(wr_count), 64'd12);
        tick();

        // 6. Grant to requester 2 (rr_ptr 1), then reset in the next cycle.
        put(2, 1'b1, 5'd9, DATA_C);
        expect_grant(2, 5'd9, DATA_C, 1'b0);
        tick();
        reset     = 1'b1;
        req_valid = '1;
        @(negedge clk);
        chk("rst_mid_ready", 64'(req_ready), 64'd0);
        chk("rst_mid_wr_en", 64'(wr_en), 64'd0);
        tick();
        reset     = 1'b0;
        req_valid = '0;
        @(negedge clk);
        chk("post_rst_wr_en", 64'(wr_en), 64'd0);
        chk("post_rst_count", 64'(wr_count), 64'd0);
        tick();

        // Re-presented requests: rr_ptr must be back at 0.
        for (int i = 0; i < N; i++) put(i, 1'b1, 5'(12 + i), 64'h6000 + 64'(i));
        expect_grant(0, 5'd12, 64'h6000, 1'b1);
        tick();
        put(0, 1'b0, 5'd0, 64'd0);
        expect_grant(1, 5'd13, 64'h6001, 1'b1);
        tick();
        req_valid = '0;
        repeat (3) tick();
        @(negedge clk);
        chk("final_count", 64'(wr_count), 64'd2);
        chk("grant_q_empty", 64'(grant_q.size()), 64'd0);
        chk("commit_q_empty", 64'(commit_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
